sc_tick_gen: RTL and testbench
==============================

# sc_tick_gen

Cycle-quantum tick generator in the HDL/SystemC co-simulation path. Counts enabled `clk` cycles and offers a "time advance" token (cycle delta plus sequence number) over a valid/ready handshake to the downstream DPI tick bridge, which calls into the SystemC kernel. Cycles that elapse while a token is stalled are carried into the next token, so no HDL time is lost. Stall and saturation statistics are exported for bring-up debug.

## Interface
- `ACC_W`, 16: width of the cycle accumulator, `quantum` and `tick_delta`.
- `SEQ_W`, 16: width of the token sequence number.
- `STALL_W`, 32: width of the stall-cycle counter.

- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-low. Sampled only on posedge `clk`.
- `enable`  in  1  count this cycle when high.
- `quantum`  in  ACC_W  cycles per token. A value of 0 is treated as 1. Sampled every cycle.
- `tick_valid`  out  1  token offered.
- `tick_ready`  in  1  downstream accepts the token.
- `tick_delta`  out  ACC_W  cycles represented by the token. Stable while `tick_valid` is high.
- `tick_seq`  out  SEQ_W  sequence number of the offered token. Stable while `tick_valid` is high.
- `stall_cnt`  out  STALL_W  cycles where `tick_valid` is high and `tick_ready` is low. Saturating.
- `acc_ovf`  out  1  sticky; the accumulator saturated and time was lost.

## Operation
- Definitions:
  - hs = `tick_valid` & `tick_ready`.
  - q_eff = max(`quantum`, 1).
  - acc = internal accumulator of enabled cycles not yet assigned to a token.
  - acc_next = acc + `enable`, saturating at 2^ACC_W−1.
  - If acc == 2^ACC_W−1 and `enable` is high, set `acc_ovf`.
- States: COUNT (`tick_valid` = 0) and PEND (`tick_valid` = 1).
- COUNT:
  - If acc_next ≥ q_eff, issue a token: `tick_delta` <= acc_next, acc <= 0, go to PEND.
  - Otherwise acc <= acc_next.
- PEND without hs:
  - acc <= acc_next, so counting continues.
  - `tick_delta` and `tick_seq` are held.
  - `stall_cnt` increments, saturating.
- PEND with hs:
  - `tick_seq` <= `tick_seq` + 1 (wraps modulo 2^SEQ_W).
  - If acc_next ≥ q_eff, reissue: `tick_delta` <= acc_next, acc <= 0, stay in PEND. Back-to-back tokens are allowed.
  - Otherwise acc <= acc_next and go to COUNT.
- `enable` low:
  - acc freezes.
  - A pending token remains offered and can still complete hs.
- A change of `quantum` takes effect at the next compare. A token already offered is not altered.
- Reset (`rst` low at a posedge), including in the middle of PEND:
  - State goes to COUNT; acc and all outputs go to 0.
  - The pending token is dropped.
  - `acc_ovf` is cleared.
  - `tick_ready` is ignored during that cycle.

## Timing
- Reset values:
  - `tick_valid` = 0
  - `tick_delta` = 0
  - `tick_seq` = 0
  - `stall_cnt` = 0
  - `acc_ovf` = 0
- All outputs are registered. There is no combinational path from `tick_ready`, `enable` or `quantum` to any output.
- Latency: the quantum-th enabled cycle after reset or after the last issue is cycle N. `tick_valid` rises in cycle N+1.
- Steady state with `enable` and `tick_ready` held at 1: one token every q_eff cycles, each with `tick_delta` = q_eff.
- With q_eff = 1 and `tick_ready` = 1: `tick_valid` stays high continuously, `tick_delta` = 1, and `tick_seq` increments every cycle.
- `tick_valid` never falls without hs, except on reset.

## Test plan
- Reset deasserted, `enable` = 1, `quantum` = 4, `tick_ready` = 1 → `tick_valid` first high in cycle 4 after reset release, then every 4 cycles; `tick_delta` = 4; `tick_seq` = 0, 1, 2, …; `stall_cnt` = 0.
- `quantum` = 4, `tick_ready` low for 10 cycles once the token is offered:
  - Token held with `tick_delta` = 4 and `stall_cnt` = 10.
  - After hs, the next token follows immediately with `tick_delta` = 10 (plus cycles counted in the hs cycle, i.e. 11).
  - Total cycles reported equals total enabled cycles.
- `quantum` = 0 with `tick_ready` = 1 → behaves as 1: continuous `tick_valid`, `tick_delta` = 1.
- `enable` toggled 1/0 every cycle, `quantum` = 3 → each token has `tick_delta` = 3 and is spaced 6 cycles apart; a pending token still completes while `enable` = 0.
- ACC_W = 4, `tick_ready` held low for 40 cycles → `acc_ovf` set; the next token's `tick_delta` = 15; `acc_ovf` stays set until reset.
- `rst` pulled low in the middle of PEND with `tick_ready` = 1 in the same cycle → no sequence increment; all outputs 0 the next cycle; `tick_seq` restarts at 0.

Source files
------------

// File: rtl/sc_tick_gen.sv
// Cycle-quantum tick generator: counts enabled cycles and offers time-advance
// tokens (delta + sequence) downstream, carrying stalled cycles into the next token.
module sc_tick_gen #(
  parameter int ACC_W   = 16,
  parameter int SEQ_W   = 16,
  parameter int STALL_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [ACC_W-1:0]   quantum,
  output logic               tick_valid,
  input  logic               tick_ready,
  output logic [ACC_W-1:0]   tick_delta,
  output logic [SEQ_W-1:0]   tick_seq,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               acc_ovf
);

  // Handshake: a token transfers on a posedge where tick_valid and tick_ready
  // are both high; tick_delta/tick_seq stay stable until then, and tick_valid
  // only drops after a transfer or on reset.
  typedef enum logic {
    COUNT = 1'b0,
    PEND  = 1'b1
  } state_e;

  localparam logic [ACC_W-1:0]   ACC_MAX   = '1;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   delta_q, delta_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   acc_next;
  logic [ACC_W-1:0]   q_eff;
  logic               acc_sat;
  logic               issue;

  always_comb begin
    acc_sat  = (acc_q == ACC_MAX);
    acc_next = (enable && !acc_sat) ? acc_q + ACC_W'(1) : acc_q;
    q_eff    = (quantum == '0) ? ACC_W'(1) : quantum;
    issue    = (acc_next >= q_eff);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_next;
    delta_d = delta_q;
    seq_d   = seq_q;
    stall_d = stall_q;
    ovf_d   = ovf_q | (acc_sat & enable);
    unique case (state_q)
      COUNT: begin
        if (issue) begin
          delta_d = acc_next;
          acc_d   = '0;
          state_d = PEND;
        end
      end
      PEND: begin
        if (!tick_ready) begin
          if (stall_q != STALL_MAX) stall_d = stall_q + STALL_W'(1);
        end else begin
          seq_d = seq_q + SEQ_W'(1);
          if (issue) begin
            // Back-to-back token carrying the cycles counted while stalled.
            delta_d = acc_next;
            acc_d   = '0;
          end else begin
            state_d = COUNT;
          end
        end
      end
      default: state_d = COUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= COUNT;
      acc_q   <= '0;
      delta_q <= '0;
      seq_q   <= '0;
      stall_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      delta_q <= delta_d;
      seq_q   <= seq_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tick_valid = (state_q == PEND);
  assign tick_delta = delta_q;
  assign tick_seq   = seq_q;
  assign stall_cnt  = stall_q;
  assign acc_ovf    = ovf_q;

endmodule

// File: tb/tb_sc_tick_gen.sv
// Directed bench for sc_tick_gen: expected tokens are queued as stimulus is
// driven and checked when the DUT completes a handshake.
module tb_sc_tick_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default-width instance
  logic        rst, enable, tick_ready;
  logic [15:0] quantum;
  logic        tick_valid, acc_ovf;
  logic [15:0] tick_delta, tick_seq;
  logic [31:0] stall_cnt;

  // Narrow-accumulator instance for saturation
  logic        rst4, en4, rdy4;
  logic [3:0]  q4;
  logic        valid4, ovf4;
  logic [3:0]  delta4;
  logic [15:0] seq4;
  logic [31:0] stall4;

  sc_tick_gen dut (
    .clk(clk), .rst(rst), .enable(enable), .quantum(quantum),
    .tick_valid(tick_valid), .tick_ready(tick_ready), .tick_delta(tick_delta),
    .tick_seq(tick_seq), .stall_cnt(stall_cnt), .acc_ovf(acc_ovf)
  );

  sc_tick_gen #(.ACC_W(4), .SEQ_W(16), .STALL_W(32)) dut4 (
    .clk(clk), .rst(rst4), .enable(en4), .quantum(q4),
    .tick_valid(valid4), .tick_ready(rdy4), .tick_delta(delta4),
    .tick_seq(seq4), .stall_cnt(stall4), .acc_ovf(ovf4)
  );

  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int sum_delta = 0;

  task automatic chk(input string tag, input logic [63:0] obsv, input logic [63:0] expv);
    n_cmp++;
    assert (obsv === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obsv, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: a handshake happens at the coming posedge when rst is high
  // and both valid and ready are high now.
  always @(negedge clk) begin
    if (rst === 1'b1 && tick_valid === 1'b1 && tick_ready === 1'b1) begin
      chk("sb_token_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_delta", 64'(tick_delta), 64'(e[31:16]));
        chk("sb_seq", 64'(tick_seq), 64'(e[15:0]));
      end
      sum_delta += int'(tick_delta);
    end
  end

  initial begin
    rst = 1'b0; enable = 1'b0; tick_ready = 1'b0; quantum = 16'd4;
    rst4 = 1'b0; en4 = 1'b0; rdy4 = 1'b0; q4 = 4'd4;
    step(2);

    // Reset values
    chk("rst_valid", 64'(tick_valid), 64'd0);
    chk("rst_delta", 64'(tick_delta), 64'd0);
    chk("rst_seq", 64'(tick_seq), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_ovf", 64'(acc_ovf), 64'd0);
    chk("rst4_valid", 64'(valid4), 64'd0);

    // Steady state, quantum 4: token after every 4th cycle
    rst = 1'b1; enable = 1'b1; tick_ready = 1'b1;
    exp_q.push_back({16'd4, 16'd0});
    exp_q.push_back({16'd4, 16'd1});
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("q4_valid", 64'(tick_valid), 64'((k % 4) == 0));
      if (k == 12) tick_ready = 1'b0;
    end
    chk("q4_delta", 64'(tick_delta), 64'd4);
    chk("q4_seq", 64'(tick_seq), 64'd2);
    chk("q4_stall", 64'(stall_cnt), 64'd0);

    // Stall for 10 cycles, then carried cycles come out back-to-back
    step(10);
    chk("stall_valid", 64'(tick_valid), 64'd1);
    chk("stall_delta", 64'(tick_delta), 64'd4);
    chk("stall_seq", 64'(tick_seq), 64'd2);
    chk("stall_cnt", 64'(stall_cnt), 64'd10);
    exp_q.push_back({16'd4, 16'd2});
    exp_q.push_back({16'd11, 16'd3});
    tick_ready = 1'b1;
    step(1);
    chk("b2b_valid", 64'(tick_valid), 64'd1);
    chk("b2b_delta", 64'(tick_delta), 64'd11);
    chk("b2b_seq", 64'(tick_seq), 64'd3);
    chk("b2b_stall", 64'(stall_cnt), 64'd10);
    step(1);
    chk("b2b_done_valid", 64'(tick_valid), 64'd0);
    chk("total_cycles", 64'(sum_delta), 64'd23);
    chk("sb_drained_1", 64'(exp_q.size()), 64'd0);

    // quantum 0 behaves as 1: continuous tokens of delta 1
    rst = 1'b0; quantum = 16'd0; enable = 1'b1; tick_ready = 1'b1;
    step(1);
    rst = 1'b1;
    for (int k = 0; k < 7; k++) exp_q.push_back({16'd1, 16'(k)});
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk("q0_valid", 64'(tick_valid), 64'd1);
      chk("q0_delta", 64'(tick_delta), 64'd1);
      chk("q0_seq", 64'(tick_seq), 64'(k - 1));
      if (k == 8) tick_ready = 1'b0;
    end
    chk("sb_drained_2", 64'(exp_q.size()), 64'd0);

    // enable toggling, quantum 3: tokens 6 cycles apart, completing with enable low
    rst = 1'b0; enable = 1'b0; quantum = 16'd3; tick_ready = 1'b1;
    step(1);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back({16'd3, 16'(k)});
    for (int k = 1; k <= 18; k++) begin
      enable = (k % 2) == 1;
      step(1);
      chk("tog_valid", 64'(tick_valid), 64'((k % 6) == 5));
    end
    chk("tog_seq", 64'(tick_seq), 64'd3);
    chk("sb_drained_3", 64'(exp_q.size()), 64'd0);
    enable = 1'b0;

    // Narrow accumulator saturates while stalled
    rst4 = 1'b1; en4 = 1'b1; q4 = 4'd4; rdy4 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (k == 19) chk("ovf4_not_yet", 64'(ovf4), 64'd0);
      if (k == 20) chk("ovf4_set", 64'(ovf4), 64'd1);
    end
    chk("ovf4_valid", 64'(valid4), 64'd1);
    chk("ovf4_delta_held", 64'(delta4), 64'd4);
    chk("ovf4_seq_held", 64'(seq4), 64'd0);
    chk("ovf4_stall", 64'(stall4), 64'd36);
    rdy4 = 1'b1;
    step(1);
    chk("ovf4_next_delta", 64'(delta4), 64'd15);
    chk("ovf4_next_seq", 64'(seq4), 64'd1);
    chk("ovf4_sticky_a", 64'(ovf4), 64'd1);
    rdy4 = 1'b0;
    step(3);
    chk("ovf4_sticky_b", 64'(ovf4), 64'd1);
    rst4 = 1'b0;
    step(1);
    chk("ovf4_cleared", 64'(ovf4), 64'd0);
    chk("rst4_valid_2", 64'(valid4), 64'd0);
    chk("rst4_seq_2", 64'(seq4), 64'd0);
    chk("rst4_stall_2", 64'(stall4), 64'd0);

    // Reset in the middle of PEND with tick_ready high
    rst = 1'b0;
    step(1);
    rst = 1'b1; quantum = 16'd2; enable = 1'b1; tick_ready = 1'b0;
    step(2);
    chk("pend_valid", 64'(tick_valid), 64'd1);
    chk("pend_delta", 64'(tick_delta), 64'd2);
    step(1);
    rst = 1'b0; tick_ready = 1'b1;
    step(1);
    chk("midrst_valid", 64'(tick_valid), 64'd0);
    chk("midrst_delta", 64'(tick_delta), 64'd0);
    chk("midrst_seq", 64'(tick_seq), 64'd0);
    chk("midrst_stall", 64'(stall_cnt), 64'd0);
    chk("midrst_ovf", 64'(acc_ovf), 64'd0);
    rst = 1'b1;
    exp_q.push_back({16'd2, 16'd0});
    step(2);
    chk("restart_valid", 64'(tick_valid), 64'd1);
    chk("restart_seq", 64'(tick_seq), 64'd0);
    step(1);
    chk("restart_done_valid", 64'(tick_valid), 64'd0);
    chk("restart_seq_inc", 64'(tick_seq), 64'd1);
    tick_ready = 1'b0;
    chk("sb_drained_4", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
